procsc_control_unit: RTL and testbench
======================================

Name: procsc_control_unit

Overview:
- Instruction fetch/decode/sequence FSM directly upstream of the single-clock processor's register-file datapath.
- Fetches 16-bit instruction words from instruction memory and keeps the program counter.
- Drives the register file's write select/enable (select, LE), read addresses (SBA, SBB), the write-data source mux and the ALU operation code.
- Consumes the ALU zero flag to resolve conditional branches.

Parameters:
- PC_W, 8, program counter width (>= 8; jump targets imm8 zero-extended).
- RESET_PC, 0, PC value after reset and after restart from HALT.

Ports:
- clk  input  1  system clock, all state updates on rising edge
- rst  input  1  asynchronous active-high reset
- start  input  1  begin execution from IDLE or restart from HALT
- instr  input  16  instruction word from instruction memory
- instr_valid  input  1  instr valid this cycle (sampled only in FETCH)
- alu_zero  input  1  ALU result == 0 for current SBA/SBB/alu_op
- instr_req  output  1  fetch request, high throughout FETCH
- pc  output  PC_W  instruction address
- select  output  4  register-file destination index
- LE  output  1  register-file load enable, one-cycle pulse
- SBA  output  4  register-file read address A
- SBB  output  4  register-file read address B
- di_sel  output  2  write-data source: 00 ALU, 01 immediate, 10 external In
- imm  output  8  immediate field to datapath
- alu_op  output  3  000 PASS-A, 001 ADD, 010 SUB, 011 AND, 100 OR, 101 XOR
- busy  output  1  high in FETCH/DECODE/EXEC
- halted  output  1  high in HALT
- illegal  output  1  sticky illegal-opcode flag (ILLEGAL_TRAP_EN only, else tied 0)

Behaviour:
- Instruction format:
  - op = instr[15:12], dst = [11:8], srcA = [7:4], srcB = [3:0], imm8 = [7:0].
- Opcodes:
  - 0 NOP.
  - 1 LDI (dst <= imm8).
  - 2 IN (dst <= external In).
  - 3 MOV (dst <= srcA, PASS-A).
  - 4 ADD, 5 SUB, 6 AND, 7 OR, 8 XOR (dst <= srcA op srcB).
  - 9 JMP imm8.
  - A JZ imm8 (taken if Z == 1).
  - F HALT.
  - B-E illegal.
- Reset (async, immediate):
  - State IDLE, pc = RESET_PC, IR = 0, Z = 0.
  - All outputs 0 except pc.
- All outputs are registered; no combinational paths from inputs to outputs.
- FSM states: IDLE, FETCH, DECODE, EXEC, HALT.
  - IDLE: start = 1 -> FETCH.
  - FETCH: instr_req = 1. On instr_valid = 1, latch instr into IR -> DECODE. Otherwise stay in FETCH indefinitely.
  - DECODE: drive select = dst, SBA = srcA, SBB = srcB, imm = imm8, di_sel, alu_op; LE = 0 -> EXEC.
  - EXEC:
    - LE = 1 for exactly this cycle for ops 1-8; select/SBA/SBB/di_sel/alu_op held from DECODE.
    - Ops 4-8 sample alu_zero into Z. Ops 1-3 leave Z unchanged.
    - pc update: JMP -> imm8; JZ with Z = 1 -> imm8; otherwise pc + 1, wrapping modulo 2^PC_W.
    - Next state: HALT for op F, else FETCH.
  - HALT: pc frozen, LE = 0. start = 1 -> pc = RESET_PC, Z = 0, then FETCH.
- Latency: 3 cycles per instruction when instr_valid is high on the first FETCH cycle; each FETCH wait cycle adds 1.
- start is ignored in FETCH/DECODE/EXEC. instr_valid is ignored outside FETCH.
- Illegal opcodes without the optional feature: executed as NOP (pc + 1, no LE).
- Reset mid-instruction: any pending LE is suppressed; the register file sees no write.

Optional Feature:
- Macro: PROCSC_ILLEGAL_TRAP_EN.
- Defined: opcode B-E in EXEC sets sticky illegal = 1 (cleared only by rst or restart start), moves to HALT and leaves pc pointing at the faulting instruction.
- Undefined: illegal is constant 0 and opcodes B-E behave as NOP.

Test Plan:
- Reset then start, instr 0x1A5C with valid on first FETCH cycle -> DECODE drives select = 0xA, imm = 0x5C, di_sel = 01; next cycle LE = 1 for one cycle; pc 0 -> 1; 3 cycles total.
- ADD 0x4312 with alu_zero = 1, then JZ 0xA040 -> SBA = 1, SBB = 2, alu_op = 001, LE pulse; Z = 1; pc becomes 0x40 after JZ with no LE.
- instr_valid held low 5 cycles in FETCH -> instr_req high 5 cycles, pc stable, no LE; completes normally on valid.
- pc = 0xFF, NOP -> pc wraps to 0x00; HALT 0xF000 -> halted = 1, busy = 0, pc frozen; start -> pc = 0, Z = 0, FETCH.
- rst asserted during EXEC of LDI -> LE = 0 immediately, state IDLE, pc = 0; no write observed.
- Opcode 0xC123: with macro, illegal = 1, halted = 1, pc unchanged; without macro, pc + 1, illegal = 0.

Source files
------------

// File: rtl/procsc_control_unit.sv
// ---------------------------------------------------------------------------
// procsc_control_unit
//
// Fetch/decode/sequence FSM for the single-clock processor. It fetches one
// 16-bit instruction word at a time, keeps the program counter, and drives
// the register file (destination select, load enable, read addresses), the
// write-data source mux and the ALU operation code. The ALU zero flag is
// captured into an internal Z bit that resolves conditional branches.
//
// Instruction word: op[15:12] dst[11:8] srcA[7:4] srcB[3:0] / imm8[7:0]
//
// Build option:
//   PROCSC_ILLEGAL_TRAP_EN - when defined, opcodes B-E set a sticky
//   'illegal' flag and halt with pc still pointing at the faulting word.
//   When undefined, 'illegal' is tied low and B-E execute as NOP.
//
// Every output comes straight from a flop; no input reaches an output
// without passing through a register.
// ---------------------------------------------------------------------------
module procsc_control_unit #(
  parameter int PC_W     = 8,
  parameter int RESET_PC = 0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [15:0]     instr,
  input  logic            instr_valid,
  input  logic            alu_zero,
  output logic            instr_req,
  output logic [PC_W-1:0] pc,
  output logic [3:0]      select,
  output logic            LE,
  output logic [3:0]      SBA,
  output logic [3:0]      SBB,
  output logic [1:0]      di_sel,
  output logic [7:0]      imm,
  output logic [2:0]      alu_op,
  output logic            busy,
  output logic            halted,
  output logic            illegal
);

  // FSM encoding
  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_FETCH  = 3'd1;
  localparam logic [2:0] S_DECODE = 3'd2;
  localparam logic [2:0] S_EXEC   = 3'd3;
  localparam logic [2:0] S_HALT   = 3'd4;

  // Opcodes
  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_LDI  = 4'h1;
  localparam logic [3:0] OP_IN   = 4'h2;
  localparam logic [3:0] OP_MOV  = 4'h3;
  localparam logic [3:0] OP_ADD  = 4'h4;
  localparam logic [3:0] OP_SUB  = 4'h5;
  localparam logic [3:0] OP_AND  = 4'h6;
  localparam logic [3:0] OP_OR   = 4'h7;
  localparam logic [3:0] OP_XOR  = 4'h8;
  localparam logic [3:0] OP_JMP  = 4'h9;
  localparam logic [3:0] OP_JZ   = 4'hA;
  localparam logic [3:0] OP_HALT = 4'hF;

  // Write-data source codes
  localparam logic [1:0] DI_ALU = 2'b00;
  localparam logic [1:0] DI_IMM = 2'b01;
  localparam logic [1:0] DI_IN  = 2'b10;

  // ALU operation codes
  localparam logic [2:0] ALU_PASS_A = 3'b000;
  localparam logic [2:0] ALU_ADD    = 3'b001;
  localparam logic [2:0] ALU_SUB    = 3'b010;
  localparam logic [2:0] ALU_AND    = 3'b011;
  localparam logic [2:0] ALU_OR     = 3'b100;
  localparam logic [2:0] ALU_XOR    = 3'b101;

  localparam logic [PC_W-1:0] PC_RST = PC_W'(RESET_PC);

  logic [2:0]  state;
  logic [2:0]  next_state;
  logic [15:0] ir;
  logic        z;
  logic [3:0]  op;
  logic        trap;
  logic        load_ir;
  logic        restart;

  assign op      = ir[15:12];
  assign load_ir = (state == S_FETCH) && instr_valid;
  assign restart = (state == S_HALT) && start;

  // Register-file addressing and the immediate are plain IR fields: they
  // change only when a new word is fetched, so they are stable from DECODE
  // through EXEC and read as zero after reset.
  assign select = ir[11:8];
  assign SBA    = ir[7:4];
  assign SBB    = ir[3:0];
  assign imm    = ir[7:0];

  // Ops that write the register file: LDI, IN, MOV and the ALU group.
  function automatic logic writes_rf(input logic [3:0] o);
    return (o >= OP_LDI) && (o <= OP_XOR);
  endfunction

  // Ops whose result updates the zero flag: the two-operand ALU group only.
  function automatic logic sets_z(input logic [3:0] o);
    return (o >= OP_ADD) && (o <= OP_XOR);
  endfunction

  function automatic logic [1:0] di_sel_of(input logic [3:0] o);
    case (o)
      OP_LDI:  return DI_IMM;
      OP_IN:   return DI_IN;
      default: return DI_ALU;
    endcase
  endfunction

  function automatic logic [2:0] alu_op_of(input logic [3:0] o);
    case (o)
      OP_ADD:  return ALU_ADD;
      OP_SUB:  return ALU_SUB;
      OP_AND:  return ALU_AND;
      OP_OR:   return ALU_OR;
      OP_XOR:  return ALU_XOR;
      default: return ALU_PASS_A;
    endcase
  endfunction

`ifdef PROCSC_ILLEGAL_TRAP_EN
  // Opcodes B-E are unassigned and trap to HALT.
  assign trap = (op >= 4'hB) && (op <= 4'hE);
`else
  // Without the trap, unassigned opcodes fall through as NOP.
  assign trap = 1'b0;
`endif

  // Next-state logic for the sequencer.
  always_comb begin
    // NOTE: default assignment first so every path assigns next_state and
    // no latch is inferred.
    next_state = state;
    case (state)
      S_IDLE:   if (start) next_state = S_FETCH;
      S_FETCH:  if (instr_valid) next_state = S_DECODE;
      S_DECODE: next_state = S_EXEC;
      S_EXEC:   next_state = ((op == OP_HALT) || trap) ? S_HALT : S_FETCH;
      S_HALT:   if (start) next_state = S_FETCH;
      default:  next_state = S_IDLE;
    endcase
  end

  // State register plus the status outputs, registered from next_state so
  // they line up exactly with the state they describe.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      instr_req <= 1'b0;
      busy      <= 1'b0;
      halted    <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments for all sequential state so every
      // flop samples values from before the clock edge.
      state     <= next_state;
      instr_req <= (next_state == S_FETCH);
      busy      <= (next_state == S_FETCH) || (next_state == S_DECODE) ||
                   (next_state == S_EXEC);
      halted    <= (next_state == S_HALT);
    end
  end

  // Instruction register and its pre-decoded datapath controls, captured
  // when a valid word arrives in FETCH.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ir     <= 16'h0000;
      di_sel <= DI_ALU;
      alu_op <= ALU_PASS_A;
    end else if (load_ir) begin
      ir     <= instr;
      di_sel <= di_sel_of(instr[15:12]);
      alu_op <= alu_op_of(instr[15:12]);
    end
  end

  // Register-file load enable: a single pulse covering the EXEC cycle of a
  // writing instruction. The async reset drops a pending pulse at once, so
  // a reset during EXEC never produces a write.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      LE <= 1'b0;
    end else begin
      LE <= (state == S_DECODE) && writes_rf(op);
    end
  end

  // Program counter: sequential advance, jumps, and reload on restart.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc <= PC_RST;
    end else if (restart) begin
      pc <= PC_RST;
    end else if (state == S_EXEC) begin
      if ((op == OP_JMP) || ((op == OP_JZ) && z)) begin
        pc <= PC_W'(ir[7:0]);
      end else if (!trap) begin
        pc <= pc + PC_W'(1);
      end
    end
  end

  // Zero flag: updated by the ALU group at the end of EXEC, cleared on
  // restart so a fresh program never inherits a stale branch condition.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      z <= 1'b0;
    end else if (restart) begin
      z <= 1'b0;
    end else if ((state == S_EXEC) && sets_z(op)) begin
      z <= alu_zero;
    end
  end

`ifdef PROCSC_ILLEGAL_TRAP_EN
  // Sticky illegal-opcode flag, cleared only by reset or a restart.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      illegal <= 1'b0;
    end else if (restart) begin
      illegal <= 1'b0;
    end else if ((state == S_EXEC) && trap) begin
      illegal <= 1'b1;
    end
  end
`else
  assign illegal = 1'b0;
`endif

endmodule

// File: tb/tb_procsc_control_unit.sv
// ---------------------------------------------------------------------------
// tb_procsc_control_unit
//
// Table of instructions with their expected decode outputs, LE pulse and
// resulting pc, applied in program order; expectations go into a queue as
// each word is presented and are popped when the DUT reaches DECODE.
// Hand-written sequences cover HALT/restart, the illegal opcode and a reset
// landing in EXEC.
// ---------------------------------------------------------------------------
module tb_procsc_control_unit;

  localparam int PC_W = 8;

  logic            clk;
  logic            rst;
  logic            start;
  logic [15:0]     instr;
  logic            instr_valid;
  logic            alu_zero;
  logic            instr_req;
  logic [PC_W-1:0] pc;
  logic [3:0]      select;
  logic            LE;
  logic [3:0]      SBA;
  logic [3:0]      SBB;
  logic [1:0]      di_sel;
  logic [7:0]      imm;
  logic [2:0]      alu_op;
  logic            busy;
  logic            halted;
  logic            illegal;

  procsc_control_unit #(.PC_W(PC_W), .RESET_PC(0)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .instr       (instr),
    .instr_valid (instr_valid),
    .alu_zero    (alu_zero),
    .instr_req   (instr_req),
    .pc          (pc),
    .select      (select),
    .LE          (LE),
    .SBA         (SBA),
    .SBB         (SBB),
    .di_sel      (di_sel),
    .imm         (imm),
    .alu_op      (alu_op),
    .busy        (busy),
    .halted      (halted),
    .illegal     (illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] instr;
    logic        az;      // alu_zero presented during EXEC
    int          waits;   // FETCH cycles with instr_valid low
    logic [3:0]  sel;
    logic [3:0]  sba;
    logic [3:0]  sbb;
    logic [7:0]  imm;
    logic [1:0]  di;
    logic [2:0]  op;
    logic        le;
    logic [7:0]  pcn;     // pc after EXEC
    logic        halt;    // halted after EXEC
    logic        ill;     // illegal after EXEC
  } vec_t;

  vec_t tbl[16];
  vec_t exp_q[$];
  vec_t v;
  int   n_tests;
  int   n_fail;
  logic [7:0] cur_pc;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present one instruction starting in FETCH and follow it to the next
  // FETCH (or HALT), checking every cycle along the way.
  task automatic run_vec(input vec_t tv);
    vec_t e;
    exp_q.push_back(tv);
    check("fetch_pc", pc, cur_pc);
    check("fetch_req", instr_req, 1);
    for (int w = 0; w < tv.waits; w++) begin
      instr_valid = 1'b0;
      instr       = 16'hF000;  // a HALT word that must be ignored
      step();
      check("wait_req", instr_req, 1);
      check("wait_pc", pc, cur_pc);
      check("wait_le", LE, 0);
    end
    instr       = tv.instr;
    instr_valid = 1'b1;
    step();
    instr_valid = 1'b0;
    instr       = 16'h0000;
    // DECODE
    if (exp_q.size() == 0) begin
      check("queue_empty", 1, 0);
      return;
    end
    e = exp_q.pop_front();
    check("dec_select", select, e.sel);
    check("dec_sba", SBA, e.sba);
    check("dec_sbb", SBB, e.sbb);
    check("dec_imm", imm, e.imm);
    check("dec_di_sel", di_sel, e.di);
    check("dec_alu_op", alu_op, e.op);
    check("dec_le", LE, 0);
    check("dec_req", instr_req, 0);
    alu_zero = e.az;
    step();
    // EXEC
    check("exec_le", LE, e.le);
    check("exec_select", select, e.sel);
    check("exec_alu_op", alu_op, e.op);
    check("exec_busy", busy, 1);
    step();
    alu_zero = 1'b0;
    // Back in FETCH or in HALT
    check("post_pc", pc, e.pcn);
    check("post_le", LE, 0);
    check("post_halted", halted, e.halt);
    check("post_busy", busy, !e.halt);
    check("post_req", instr_req, !e.halt);
    check("post_illegal", illegal, e.ill);
    cur_pc = e.pcn;
  endtask

  initial begin
    n_tests     = 0;
    n_fail      = 0;
    cur_pc      = 8'h00;
    rst         = 1'b1;
    start       = 1'b0;
    instr       = 16'h0000;
    instr_valid = 1'b0;
    alu_zero    = 1'b0;

    //          instr    az    w  sel   sba   sbb   imm    di     op     le    pcn    halt  ill
    tbl[0]  = '{16'h1A5C, 1'b0, 0, 4'hA, 4'h5, 4'hC, 8'h5C, 2'd1, 3'd0, 1'b1, 8'h01, 1'b0, 1'b0};
    tbl[1]  = '{16'h4312, 1'b1, 0, 4'h3, 4'h1, 4'h2, 8'h12, 2'd0, 3'd1, 1'b1, 8'h02, 1'b0, 1'b0};
    tbl[2]  = '{16'hA040, 1'b0, 0, 4'h0, 4'h4, 4'h0, 8'h40, 2'd0, 3'd0, 1'b0, 8'h40, 1'b0, 1'b0};
    tbl[3]  = '{16'h2700, 1'b0, 5, 4'h7, 4'h0, 4'h0, 8'h00, 2'd2, 3'd0, 1'b1, 8'h41, 1'b0, 1'b0};
    tbl[4]  = '{16'h5ABC, 1'b0, 0, 4'hA, 4'hB, 4'hC, 8'hBC, 2'd0, 3'd2, 1'b1, 8'h42, 1'b0, 1'b0};
    tbl[5]  = '{16'hA010, 1'b0, 0, 4'h0, 4'h1, 4'h0, 8'h10, 2'd0, 3'd0, 1'b0, 8'h43, 1'b0, 1'b0};
    tbl[6]  = '{16'h6123, 1'b1, 0, 4'h1, 4'h2, 4'h3, 8'h23, 2'd0, 3'd3, 1'b1, 8'h44, 1'b0, 1'b0};
    tbl[7]  = '{16'h3DE0, 1'b0, 0, 4'hD, 4'hE, 4'h0, 8'hE0, 2'd0, 3'd0, 1'b1, 8'h45, 1'b0, 1'b0};
    tbl[8]  = '{16'hA077, 1'b0, 0, 4'h0, 4'h7, 4'h7, 8'h77, 2'd0, 3'd0, 1'b0, 8'h77, 1'b0, 1'b0};
    tbl[9]  = '{16'h7456, 1'b0, 0, 4'h4, 4'h5, 4'h6, 8'h56, 2'd0, 3'd4, 1'b1, 8'h78, 1'b0, 1'b0};
    tbl[10] = '{16'h8789, 1'b1, 0, 4'h7, 4'h8, 4'h9, 8'h89, 2'd0, 3'd5, 1'b1, 8'h79, 1'b0, 1'b0};
    tbl[11] = '{16'h1BFF, 1'b0, 0, 4'hB, 4'hF, 4'hF, 8'hFF, 2'd1, 3'd0, 1'b1, 8'h7A, 1'b0, 1'b0};
    tbl[12] = '{16'hA0FE, 1'b0, 0, 4'h0, 4'hF, 4'hE, 8'hFE, 2'd0, 3'd0, 1'b0, 8'hFE, 1'b0, 1'b0};
    tbl[13] = '{16'h0000, 1'b0, 0, 4'h0, 4'h0, 4'h0, 8'h00, 2'd0, 3'd0, 1'b0, 8'hFF, 1'b0, 1'b0};
    tbl[14] = '{16'h4000, 1'b1, 0, 4'h0, 4'h0, 4'h0, 8'h00, 2'd0, 3'd1, 1'b1, 8'h00, 1'b0, 1'b0};
    tbl[15] = '{16'hF000, 1'b0, 0, 4'h0, 4'h0, 4'h0, 8'h00, 2'd0, 3'd0, 1'b0, 8'h01, 1'b1, 1'b0};

    // Reset state
    step();
    step();
    check("rst_pc", pc, 0);
    check("rst_le", LE, 0);
    check("rst_busy", busy, 0);
    check("rst_halted", halted, 0);
    check("rst_req", instr_req, 0);
    check("rst_select", select, 0);
    check("rst_imm", imm, 0);
    check("rst_di_sel", di_sel, 0);
    check("rst_alu_op", alu_op, 0);
    check("rst_illegal", illegal, 0);
    rst = 1'b0;
    step();
    check("idle_busy", busy, 0);
    start = 1'b1;
    step();
    start = 1'b0;
    check("start_busy", busy, 1);

    // Main program, including JZ taken/not-taken, FETCH stall, wrap, HALT
    for (int i = 0; i < 16; i++) begin
      run_vec(tbl[i]);
    end

    // HALT holds pc and ignores instr_valid
    instr_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("halt_pc", pc, 8'h01);
      check("halt_halted", halted, 1);
      check("halt_busy", busy, 0);
      check("halt_le", LE, 0);
    end
    instr_valid = 1'b0;

    // Restart: pc back to 0, Z cleared (JZ must fall through)
    start = 1'b1;
    step();
    start = 1'b0;
    check("restart_pc", pc, 0);
    check("restart_req", instr_req, 1);
    check("restart_halted", halted, 0);
    cur_pc = 8'h00;
    v = '{16'hA055, 1'b0, 0, 4'h0, 4'h5, 4'h5, 8'h55, 2'd0, 3'd0, 1'b0, 8'h01, 1'b0, 1'b0};
    run_vec(v);

    // Illegal opcode
`ifdef PROCSC_ILLEGAL_TRAP_EN
    v = '{16'hC123, 1'b0, 0, 4'h1, 4'h2, 4'h3, 8'h23, 2'd0, 3'd0, 1'b0, 8'h01, 1'b1, 1'b1};
    run_vec(v);
    start = 1'b1;
    step();
    start = 1'b0;
    check("trap_restart_illegal", illegal, 0);
    check("trap_restart_pc", pc, 0);
    cur_pc = 8'h00;
`else
    v = '{16'hC123, 1'b0, 0, 4'h1, 4'h2, 4'h3, 8'h23, 2'd0, 3'd0, 1'b0, 8'h02, 1'b0, 1'b0};
    run_vec(v);
`endif

    // Reset arriving during EXEC of an LDI suppresses the write at once
    instr       = 16'h1344;
    instr_valid = 1'b1;
    step();
    instr_valid = 1'b0;
    step();
    check("exec_ldi_le", LE, 1);
    rst = 1'b1;
    #1;
    check("midrst_le", LE, 0);
    check("midrst_pc", pc, 0);
    check("midrst_busy", busy, 0);
    check("midrst_req", instr_req, 0);
    check("midrst_select", select, 0);
    step();
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      check("post_rst_le", LE, 0);
      check("post_rst_busy", busy, 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
